// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// A request is accepted in IDLE, its operands drive the ALU for one EXEC cycle,
// the result is captured, then held in RESP until the granted requester accepts it.
module alu_share_arbiter #(
  parameter int unsigned DW  = 32,
  parameter int unsigned OPW = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [1:0]     req_valid,
  output logic [1:0]     req_ready,
  input  logic [DW-1:0]  req0_a,
  input  logic [DW-1:0]  req1_a,
  input  logic [DW-1:0]  req0_b,
  input  logic [DW-1:0]  req1_b,
  input  logic [OPW-1:0] req0_op,
  input  logic [OPW-1:0] req1_op,
  input  logic           req0_ior,
  input  logic           req1_ior,
  output logic [1:0]     rsp_valid,
  input  logic [1:0]     rsp_ready,
  output logic [DW-1:0]  rsp_result,
  output logic [3:0]     rsp_nzcv,
  output logic           rsp_carry,
  output logic [DW-1:0]  alu_a,
  output logic [DW-1:0]  alu_b,
  output logic [OPW-1:0] alu_op,
  output logic           alu_ior,
  input  logic [DW-1:0]  alu_result,
  input  logic [3:0]     alu_nzcv,
  input  logic           alu_carry,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   last_grant_q;
  logic   grant_q;
  logic   winner_c;
  logic   accept_c;

  // Round-robin pick: sole valid requester wins, a tie goes to the one not served last.
  always_comb begin
    winner_c = 1'b0;
    case (req_valid)
      2'b10:   winner_c = 1'b1;
      2'b11:   winner_c = ~last_grant_q;
      default: winner_c = 1'b0;
    endcase
  end

  // Next-state and the combinational accept; ready is withheld while in reset.
  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    accept_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rst_n && req_valid[winner_c]) begin
          req_ready = 2'(2'b01 << winner_c);
          accept_c  = 1'b1;
          state_d   = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready[grant_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand capture on accept; grant bookkeeping for round-robin and response steering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_op       <= '0;
      alu_ior      <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept_c) begin
      alu_a        <= winner_c ? req1_a   : req0_a;
      alu_b        <= winner_c ? req1_b   : req0_b;
      alu_op       <= winner_c ? req1_op  : req0_op;
      alu_ior      <= winner_c ? req1_ior : req0_ior;
      grant_q      <= winner_c;
      last_grant_q <= winner_c;
    end
  end

  // Result capture: loads only at the end of the single EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_nzcv   <= 4'b0000;
      rsp_carry  <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_result <= alu_result;
      rsp_nzcv   <= alu_nzcv;
      rsp_carry  <= alu_carry;
    end
  end

  // Registered status: response valid steered to the granted requester, busy outside IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 2'b00;
      busy      <= 1'b0;
    end else begin
      rsp_valid <= (state_d == RESP) ? 2'(2'b01 << grant_q) : 2'b00;
      busy      <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed cases pinned with literal values,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_alu_share_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned OPW = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [DW-1:0]  req0_a, req1_a, req0_b, req1_b;
  logic [OPW-1:0] req0_op, req1_op;
  logic           req0_ior, req1_ior;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [DW-1:0]  rsp_result;
  logic [3:0]     rsp_nzcv;
  logic           rsp_carry;
  logic [DW-1:0]  alu_a, alu_b;
  logic [OPW-1:0] alu_op;
  logic           alu_ior;
  logic [DW-1:0]  alu_result;
  logic [3:0]     alu_nzcv;
  logic           alu_carry;
  logic           busy;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DW(DW), .OPW(OPW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req0_a(req0_a), .req1_a(req1_a), .req0_b(req0_b), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op), .req0_ior(req0_ior), .req1_ior(req1_ior),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_nzcv(rsp_nzcv), .rsp_carry(rsp_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_ior(alu_ior),
    .alu_result(alu_result), .alu_nzcv(alu_nzcv), .alu_carry(alu_carry),
    .busy(busy)
  );

  // Stand-in ALU: {nzcv, carry, result}. 1 add, 2 subtract, 3 and, otherwise xor.
  function automatic logic [DW+4:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                           input logic [OPW-1:0] op);
    logic [DW:0]   s;
    logic [DW-1:0] r;
    logic          c, v;
    s = '0; c = 1'b0; v = 1'b0;
    case (op[2:0])
      3'd1: begin
        s = {1'b0, a} + {1'b0, b}; r = s[DW-1:0]; c = s[DW];
        v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      3'd2: begin
        s = {1'b0, a} - {1'b0, b}; r = s[DW-1:0]; c = ~s[DW];
        v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]);
      end
      3'd3:    r = a & b;
      default: r = a ^ b;
    endcase
    return {r[DW-1], (r == '0), c, v, c, r};
  endfunction

  always_comb {alu_nzcv, alu_carry, alu_result} = alu_fn(alu_a, alu_b, alu_op);

  // Transaction model: m_age counts where the accepted operation is (0 none, 1 executing, 2 awaiting accept).
  int             m_age;
  logic           m_last, m_grant;
  logic [DW-1:0]  m_a, m_b, m_res;
  logic [OPW-1:0] m_op;
  logic           m_ior, m_carry;
  logic [3:0]     m_nzcv;

  task automatic model_reset();
    m_age = 0; m_last = 1'b1; m_grant = 1'b0;
    m_a = '0; m_b = '0; m_op = '0; m_ior = 1'b0;
    m_res = '0; m_nzcv = 4'b0000; m_carry = 1'b0;
  endtask

  function automatic int pick();
    if (req_valid == 2'b01) return 0;
    if (req_valid == 2'b10) return 1;
    if (req_valid == 2'b11) return (m_last == 1'b0) ? 1 : 0;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic check_ready();
    int w;
    logic [1:0] e;
    w = pick();
    e = 2'b00;
    if (m_age == 0 && w >= 0) e = (w == 1) ? 2'b10 : 2'b01;
    check("req_ready", 64'(req_ready), 64'(e));
  endtask

  task automatic check_regs();
    logic [1:0] ev;
    ev = (m_age == 2) ? (m_grant ? 2'b10 : 2'b01) : 2'b00;
    check("busy", 64'(busy), 64'(m_age != 0));
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    check("rsp_result", 64'(rsp_result), 64'(m_res));
    check("rsp_nzcv", 64'(rsp_nzcv), 64'(m_nzcv));
    check("rsp_carry", 64'(rsp_carry), 64'(m_carry));
    check("alu_a", 64'(alu_a), 64'(m_a));
    check("alu_b", 64'(alu_b), 64'(m_b));
    check("alu_op", 64'(alu_op), 64'(m_op));
    check("alu_ior", 64'(alu_ior), 64'(m_ior));
  endtask

  task automatic model_edge();
    int w;
    case (m_age)
      0: begin
        w = pick();
        if (w >= 0) begin
          m_grant = (w == 1); m_last = (w == 1);
          m_a   = m_grant ? req1_a   : req0_a;
          m_b   = m_grant ? req1_b   : req0_b;
          m_op  = m_grant ? req1_op  : req0_op;
          m_ior = m_grant ? req1_ior : req0_ior;
          m_age = 1;
        end
      end
      1: begin
        {m_nzcv, m_carry, m_res} = alu_fn(m_a, m_b, m_op);
        m_age = 2;
      end
      default: if (rsp_ready[m_grant]) m_age = 0;
    endcase
  endtask

  // One clock: inputs already set at the falling edge by the caller.
  task automatic cycle();
    #1 check_ready();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_regs();
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    #1;
    check("rst busy", 64'(busy), 64'd0);
    check("rst rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst req_ready", 64'(req_ready), 64'd0);
    check("rst rsp_result", 64'(rsp_result), 64'd0);
    check("rst alu_a", 64'(alu_a), 64'd0);
    check("rst alu_op", 64'(alu_op), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [OPW-1:0] op, input logic ior);
    if (id == 0) begin req0_a = a; req0_b = b; req0_op = op; req0_ior = ior; end
    else begin req1_a = a; req1_b = b; req1_op = op; req1_ior = ior; end
  endtask

  initial begin
    logic [1:0] seq [$];
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    set_req(0, '0, '0, '0, 1'b0);
    set_req(1, '0, '0, '0, 1'b0);
    model_reset();
    req_valid = 2'b11;
    @(negedge clk);
    reset_now();
    req_valid = 2'b00;

    // Single requester 0 add: 5 + 3.
    set_req(0, 32'd5, 32'd3, 4'b1001, 1'b1);
    req_valid = 2'b01;
    #1 check("lit ready0", 64'(req_ready), 64'b01);
    cycle();
    req_valid = 2'b00;
    cycle();
    check("lit rv0", 64'(rsp_valid), 64'b01);
    check("lit res8", 64'(rsp_result), 64'd8);
    check("lit nzcv0", 64'(rsp_nzcv), 64'b0000);
    rsp_ready = 2'b01;
    cycle();

    // Requester 1 subtract 3 - 5, response held off; wrong-bit ready ignored.
    set_req(1, 32'd3, 32'd5, 4'b1010, 1'b0);
    req_valid = 2'b10; rsp_ready = 2'b00;
    cycle();
    req_valid = 2'b00;
    cycle();
    req_valid = 2'b11; rsp_ready = 2'b01;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("lit hold rv", 64'(rsp_valid), 64'b10);
      check("lit hold res", 64'(rsp_result), 64'hFFFF_FFFE);
      check("lit hold n", 64'(rsp_nzcv[3]), 64'd1);
      check("lit hold ready", 64'(req_ready), 64'b00);
    end
    req_valid = 2'b00; rsp_ready = 2'b10;
    cycle();

    // Fairness from reset: both continuously valid, response always accepted.
    reset_now();
    set_req(0, 32'd10, 32'd1, 4'b0001, 1'b0);
    set_req(1, 32'd20, 32'd2, 4'b0010, 1'b1);
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 9; i++) begin
      cycle();
      if (rsp_valid != 2'b00) seq.push_back(rsp_valid);
    end
    check("lit fair count", 64'(seq.size()), 64'd3);
    if (seq.size() == 3) begin
      check("lit fair g0", 64'(seq[0]), 64'b01);
      check("lit fair g1", 64'(seq[1]), 64'b10);
      check("lit fair g2", 64'(seq[2]), 64'b01);
    end

    // Reset during EXEC discards the operation.
    req_valid = 2'b00; rsp_ready = 2'b00;
    cycle();
    cycle();
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00;
    #2 reset_now();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("lit no rsp", 64'(rsp_valid), 64'b00);
    end

    // Zero AND sets Z.
    set_req(0, 32'd0, 32'd0, 4'b1011, 1'b0);
    req_valid = 2'b01; rsp_ready = 2'b01;
    cycle();
    req_valid = 2'b00;
    cycle();
    check("lit res0", 64'(rsp_result), 64'd0);
    check("lit z", 64'(rsp_nzcv[2]), 64'd1);
    cycle();
    check("lit idle busy", 64'(busy), 64'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      set_req(0, $urandom, ($urandom_range(0, 3) == 0) ? req0_a : $urandom,
              4'($urandom), 1'($urandom));
      set_req(1, $urandom, $urandom, 4'($urandom), 1'($urandom));
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
